rng_harvester: RTL and testbench
================================

Name: rng_harvester

Overview:
- Consumer end of the ring-oscillator RNG's output state bus.
- Samples the raw LHCA word at a programmable rate, XOR-folds each sample to one bit, applies von Neumann debiasing, and packs the resulting bits into words.
- Buffers packed words in a small FIFO that a downstream crypto client drains over a valid/ready handshake.
- Runs a repetition-count health test on the raw samples and locks out output on failure.

Parameters:
- IN_WIDTH, 32: width of the raw RNG state bus.
- OUT_WIDTH, 32: bits per packed output word (≥2).
- FIFO_DEPTH, 4: output FIFO entries (power of two, ≥2).
- SAMPLE_DIV, 8: clk cycles per raw sample (≥1).
- REP_LIMIT, 4: number of consecutive identical raw samples that trips the health failure (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- en_i  input  1  harvest enable
- raw_i  input  IN_WIDTH  raw RNG state word
- clear_fail_i  input  1  one-cycle pulse that clears the FAIL state
- rnd_data_o  output  OUT_WIDTH  head-of-FIFO word
- rnd_valid_o  output  1  FIFO non-empty
- rnd_ready_i  input  1  consumer accepts rnd_data_o
- fifo_level_o  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- health_fail_o  output  1  sticky health failure flag

Behaviour:
- Reset (async, rst=1) clears everything:
  - state=IDLE; all counters, pair flag, accumulator and FIFO cleared.
  - Outputs: rnd_data_o=0, rnd_valid_o=0, fifo_level_o=0, health_fail_o=0.
- States: IDLE, COLLECT, WRITE, FAIL.
  - IDLE → COLLECT when en_i=1.
  - COLLECT/WRITE → IDLE when en_i=0. Partial accumulator, bit count, pair flag and divider are discarded. FIFO contents are retained and remain readable.
- Sample strobe:
  - Divider counts 0..SAMPLE_DIV-1, only in COLLECT.
  - A sample is taken in the cycle the divider equals SAMPLE_DIV-1; the divider then wraps to 0.
  - With SAMPLE_DIV=1, a sample is taken every COLLECT cycle.
- Fold: f = XOR reduction of raw_i at the sample.
- Debias:
  - First sample of a pair: store f, set pair flag.
  - Second sample: (a,b)=01 emits 0; 10 emits 1; 00 and 11 emit nothing. Pair flag is cleared in all cases.
- Pack:
  - An emitted bit shifts into the accumulator LSB; the first bit of a word ends at the MSB.
  - bit_cnt increments per emitted bit. When it reaches OUT_WIDTH, go to WRITE.
- WRITE:
  - If the FIFO is not full, or a pop occurs the same cycle: push the accumulator, set bit_cnt=0, return to COLLECT next cycle.
  - Otherwise stay in WRITE (stall); samples are not taken.
- Health test (in COLLECT, every sample):
  - Compare raw_i with the previous sample; equal increments rep_cnt, unequal resets it to 1.
  - The first sample after entering COLLECT has no predecessor and sets rep_cnt=1.
  - When rep_cnt reaches REP_LIMIT, enter FAIL on the next cycle.
  - The health test takes priority over debias/pack on the tripping sample; no bit is emitted from it.
- FAIL:
  - health_fail_o=1; FIFO flushed (fifo_level_o=0, rnd_valid_o=0).
  - No sampling; pops are ignored.
  - Exit to IDLE only on clear_fail_i, which clears health_fail_o; en_i has no effect in FAIL.
  - clear_fail_i outside FAIL is ignored.
- FIFO:
  - First-word-fall-through: rnd_data_o = head when rnd_valid_o=1, otherwise 0.
  - Pop on rnd_valid_o & rnd_ready_i.
  - Simultaneous push and pop leaves the level unchanged. A push while full with no pop never occurs (stalls in WRITE).
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a word needs ≥2·OUT_WIDTH samples. rnd_valid_o rises the cycle after the push.

Test Plan:
(All directed tests use OUT_WIDTH=8, SAMPLE_DIV=1, FIFO_DEPTH=4, REP_LIMIT=4; 0x3 has parity 0, 0x1 parity 1.)
- Reset mid-operation: assert rst asynchronously with 2 words queued and 5 bits accumulated → all outputs 0 immediately; after release with en_i=1 the first word needs 16 fresh samples.
- Alternate raw_i 0x1,0x3 (pairs 10) for 16 samples → one word 0xFF; rnd_valid_o=1 the cycle after the push; pop with ready → fifo_level_o 1→0.
- Pairs 10,01 repeated, raw_i 0x1,0x3,0x3,0x1 ..., for 16 samples → word 0xAA. Interleaving 00/11 pairs (0x3,0x5 and 0x1,0x2) → same 0xAA, with emitted-bit count unaffected by discards.
- Backpressure: rnd_ready_i=0, produce 5 words' worth of samples → level 4, state held in WRITE, no samples consumed. Raise ready for one cycle → pop and push in the same cycle, level stays 4.
- Health: after 3 good words, drive raw_i=0x7 for 4 consecutive samples → health_fail_o=1 the next cycle, level 0, rnd_valid_o=0. Toggling en_i does not clear it; clear_fail_i pulse → IDLE, flag 0.
- SAMPLE_DIV=8: samples land exactly every 8th COLLECT cycle. Dropping en_i after 3 emitted bits, then re-enabling → partial bits discarded, word completes after 8 new emitted bits.

Source files
------------

// File: rtl/rng_harvester.sv
// Consumer end of the ring-oscillator RNG: samples the raw state word, XOR-folds it to one bit,
// von Neumann debiases, packs bits into words, buffers them in a FWFT FIFO and health-checks samples.
module rng_harvester #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SAMPLE_DIV = 8,
  parameter int REP_LIMIT  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en_i,
  input  logic [IN_WIDTH-1:0]                raw_i,
  input  logic                               clear_fail_i,
  output logic [OUT_WIDTH-1:0]               rnd_data_o,
  output logic                               rnd_valid_o,
  input  logic                               rnd_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               health_fail_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = $clog2(OUT_WIDTH + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);
  localparam logic [CW-1:0] BITS_LAST = CW'(OUT_WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FAIL} state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          div_cnt;
  logic [RW-1:0]          rep_cnt, rep_nxt;
  logic                   have_prev;
  logic [IN_WIDTH-1:0]    prev_raw;
  logic                   pair, pair_bit;
  logic [OUT_WIDTH-1:0]   acc;
  logic [CW-1:0]          bit_cnt;
  logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          count;

  logic sample, fold, trip, emit, word_done, push, pop, full, drop_partial;

  assign fold         = ^raw_i;
  assign sample       = (state == COLLECT) && en_i && (div_cnt == DIV_LAST);
  assign rep_nxt      = (have_prev && (raw_i == prev_raw)) ? rep_cnt + RW'(1) : RW'(1);
  // The tripping sample never reaches the debiaser.
  assign trip         = sample && (rep_nxt == REP_MAX);
  assign emit         = sample && !trip && pair && (pair_bit != fold);
  assign word_done    = emit && (bit_cnt == BITS_LAST);
  assign full         = (count == LVL_FULL);
  assign rnd_valid_o  = (count != '0);
  assign pop          = rnd_valid_o && rnd_ready_i && (state != FAIL);
  assign push         = (state == WRITE) && en_i && (!full || pop);
  assign drop_partial = (state == IDLE) || (state == FAIL) || !en_i;

  assign rnd_data_o    = rnd_valid_o ? mem[rd_ptr] : '0;
  assign fifo_level_o  = count;
  assign health_fail_o = (state == FAIL);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i) state_nxt = COLLECT;
      COLLECT: begin
        if (!en_i)          state_nxt = IDLE;
        else if (trip)      state_nxt = FAIL;
        else if (word_done) state_nxt = WRITE;
      end
      WRITE: begin
        if (!en_i)     state_nxt = IDLE;
        else if (push) state_nxt = COLLECT;
      end
      FAIL:    if (clear_fail_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      rep_cnt   <= '0;
      have_prev <= 1'b0;
      pair      <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == COLLECT) && en_i)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      else
        div_cnt <= '0;
      // A new COLLECT session starts without a predecessor sample.
      if ((state == IDLE) || (state == FAIL)) begin
        have_prev <= 1'b0;
        rep_cnt   <= '0;
      end else if (sample) begin
        have_prev <= 1'b1;
        rep_cnt   <= rep_nxt;
      end
      if (drop_partial) begin
        pair    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (sample && !trip) pair <= !pair;
        if (push)            bit_cnt <= '0;
        else if (emit)       bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample)          prev_raw <= raw_i;
    if (sample && !pair) pair_bit <= fold;
    if (emit)            acc      <= {acc[OUT_WIDTH-2:0], pair_bit};
    if (push)            mem[wr_ptr] <= acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if ((state == FAIL) || (state_nxt == FAIL)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_harvester.sv
// Directed bench for rng_harvester: a bit-level reference model pushes expected words into a
// queue as samples are driven; words are popped and compared when the bench drains the FIFO.
module tb_rng_harvester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] raw = '0;

  logic [7:0] data1, data8;
  logic       v1, v8, f1, f8;
  logic [2:0] l1, l8;

  always #5 clk = ~clk;

  rng_harvester #(.IN_WIDTH(32), .OUT_WIDTH(8), .FIFO_DEPTH(4), .SAMPLE_DIV(1), .REP_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .en_i(en), .raw_i(raw), .clear_fail_i(clr),
    .rnd_data_o(data1), .rnd_valid_o(v1), .rnd_ready_i(ready),
    .fifo_level_o(l1), .health_fail_o(f1));

  rng_harvester #(.IN_WIDTH(32), .OUT_WIDTH(8), .FIFO_DEPTH(4), .SAMPLE_DIV(8), .REP_LIMIT(4)) dut8 (
    .clk(clk), .rst(rst), .en_i(en), .raw_i(raw), .clear_fail_i(clr),
    .rnd_data_o(data8), .rnd_valid_o(v8), .rnd_ready_i(ready),
    .fifo_level_o(l8), .health_fail_o(f8));

  int         checks = 0;
  int         failures = 0;
  logic [7:0] q[$];
  bit         sel8 = 1'b0;
  bit         m_pair, m_a;
  logic [7:0] m_acc;
  int         m_cnt, m_level;

  function automatic logic [31:0] o_data();  return sel8 ? {24'b0, data8} : {24'b0, data1}; endfunction
  function automatic logic [31:0] o_valid(); return sel8 ? {31'b0, v8} : {31'b0, v1};       endfunction
  function automatic logic [31:0] o_level(); return sel8 ? {29'b0, l8} : {29'b0, l1};       endfunction
  function automatic logic [31:0] o_fail();  return sel8 ? {31'b0, f8} : {31'b0, f1};       endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pair = 1'b0;
    m_cnt  = 0;
  endtask

  // Reference: fold, von Neumann pair, MSB-first packing.
  task automatic model_sample(input logic [31:0] r);
    bit f;
    f = ^r;
    if (!m_pair) begin
      m_a    = f;
      m_pair = 1'b1;
    end else begin
      m_pair = 1'b0;
      if (m_a != f) begin
        m_acc = {m_acc[6:0], m_a};
        m_cnt++;
      end
    end
    if (m_cnt == 8) begin
      q.push_back(m_acc);
      m_cnt = 0;
    end
  endtask

  // Off-strobe cycles carry the parity-inverted value so a mistimed sample corrupts the word.
  task automatic do_sample(input logic [31:0] r);
    int n;
    n = sel8 ? 8 : 1;
    for (int i = 0; i < n - 1; i++) begin
      raw = r ^ 32'h2;
      @(negedge clk);
    end
    raw = r;
    @(negedge clk);
    model_sample(r);
  endtask

  task automatic gen_bits(input logic [7:0] w, input int nbits);
    for (int b = 7; b > 7 - nbits; b--) begin
      if (w[b]) begin do_sample(32'h1); do_sample(32'h3); end
      else      begin do_sample(32'h3); do_sample(32'h1); end
    end
  endtask

  task automatic wcycle();
    @(negedge clk);
    m_level++;
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  task automatic go_collect();
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=scoreboard_empty expected=word", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, o_valid(), 32'd1);
      chk(tag, o_data(), {24'b0, e});
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    m_level--;
  endtask

  initial begin
    model_reset();
    m_level = 0;
    m_acc   = '0;

    // Reset state
    @(negedge clk);
    chk("rst_data", o_data(), 32'd0);
    chk("rst_valid", o_valid(), 32'd0);
    chk("rst_level", o_level(), 32'd0);
    chk("rst_fail", o_fail(), 32'd0);
    chk("rst_level8", {29'b0, l8}, 32'd0);
    rst = 1'b0;

    // All pairs 10 -> 0xFF, valid the cycle after the push
    go_collect();
    gen_bits(8'hFF, 8);
    chk("a_valid_pre", o_valid(), 32'd0);
    chk("a_level_pre", o_level(), 32'd0);
    wcycle();
    chk("a_valid_post", o_valid(), 32'd1);
    chk("a_level_post", o_level(), 32'd1);
    go_idle();
    chk("a_level_idle", o_level(), 32'd1);
    pop_chk("a_word");
    chk("a_level_drained", o_level(), 32'd0);
    chk("a_data_empty", o_data(), 32'd0);

    // 10,01 pairs -> 0xAA; then the same with 00/11 pairs interleaved
    go_collect();
    for (int i = 0; i < 4; i++) begin
      do_sample(32'h1); do_sample(32'h3); do_sample(32'h3); do_sample(32'h1);
    end
    wcycle();
    chk("b_level1", o_level(), 32'd1);
    for (int i = 0; i < 4; i++) begin
      do_sample(32'h3); do_sample(32'h5); do_sample(32'h1); do_sample(32'h3);
      do_sample(32'h1); do_sample(32'h2); do_sample(32'h3); do_sample(32'h1);
    end
    wcycle();
    chk("b_level2", o_level(), 32'd2);
    go_idle();
    pop_chk("b_word_plain");
    pop_chk("b_word_discards");

    // Backpressure: fill, stall in WRITE, then simultaneous pop and push
    go_collect();
    gen_bits(8'h11, 8); wcycle();
    gen_bits(8'h22, 8); wcycle();
    gen_bits(8'h33, 8); wcycle();
    gen_bits(8'h44, 8); wcycle();
    chk("c_level_full", o_level(), 32'd4);
    gen_bits(8'h55, 8);
    for (int i = 0; i < 5; i++) begin
      raw = 32'h7;
      @(negedge clk);
      chk("c_stall_level", o_level(), 32'd4);
      chk("c_stall_fail", o_fail(), 32'd0);
    end
    pop_chk("c_word_11");
    m_level++;
    chk("c_level_popush", o_level(), 32'd4);
    go_idle();
    pop_chk("c_word_22");
    pop_chk("c_word_33");
    pop_chk("c_word_44");
    pop_chk("c_word_55");
    chk("c_level_empty", o_level(), 32'd0);

    // Health test trip, sticky flag, clear
    go_collect();
    gen_bits(8'hC3, 8); wcycle();
    gen_bits(8'h5A, 8); wcycle();
    gen_bits(8'h0F, 8); wcycle();
    chk("d_level3", o_level(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      do_sample(32'h7);
      chk("d_pre_fail", o_fail(), 32'd0);
      chk("d_pre_level", o_level(), 32'd3);
    end
    do_sample(32'h7);
    q.delete();
    m_level = 0;
    chk("d_fail", o_fail(), 32'd1);
    chk("d_fail_level", o_level(), 32'd0);
    chk("d_fail_valid", o_valid(), 32'd0);
    chk("d_fail_data", o_data(), 32'd0);
    ready = 1'b1;
    en = 1'b0;
    @(negedge clk);
    chk("d_fail_en0", o_fail(), 32'd1);
    en = 1'b1;
    @(negedge clk);
    chk("d_fail_en1", o_fail(), 32'd1);
    chk("d_fail_nopop", o_level(), 32'd0);
    ready = 1'b0;
    en = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("d_cleared", o_fail(), 32'd0);
    model_reset();
    @(negedge clk);
    chk("d_idle_fail", o_fail(), 32'd0);
    chk("d_idle_level", o_level(), 32'd0);
    go_collect();
    gen_bits(8'hE7, 8); wcycle();
    go_idle();
    pop_chk("d_word_after_clear");

    // Asynchronous reset mid-operation
    go_collect();
    gen_bits(8'h81, 8); wcycle();
    gen_bits(8'h42, 8); wcycle();
    gen_bits(8'hB0, 5);
    chk("e_level_before", o_level(), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("e_rst_data", o_data(), 32'd0);
    chk("e_rst_valid", o_valid(), 32'd0);
    chk("e_rst_level", o_level(), 32'd0);
    chk("e_rst_fail", o_fail(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_level = 0;
    model_reset();
    go_collect();
    gen_bits(8'h3C, 7);
    do_sample(32'h3);
    chk("e_level_15", o_level(), 32'd0);
    do_sample(32'h1);
    wcycle();
    chk("e_level_16", o_level(), 32'd1);
    go_idle();
    pop_chk("e_word_fresh");

    // SAMPLE_DIV=8 instance: strobe timing and partial-word discard
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_level = 0;
    model_reset();
    sel8 = 1'b1;
    go_collect();
    gen_bits(8'h5C, 8); wcycle();
    chk("f_level1", o_level(), 32'd1);
    gen_bits(8'hA0, 3);
    go_idle();
    go_collect();
    gen_bits(8'hB4, 7);
    do_sample(32'h3);
    chk("f_level_15", o_level(), 32'd1);
    do_sample(32'h1);
    wcycle();
    chk("f_level2", o_level(), 32'd2);
    go_idle();
    pop_chk("f_word_5c");
    pop_chk("f_word_b4");
    chk("f_level_empty", o_level(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
